// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared FS codes, opcode/funct constants, FSM states and the
//            per-state registered output image for the MIPS control FSM.
// Revision : 1.0
// ============================================================================
package mips_pkg;

    localparam logic [4:0] FS_ADD     = 5'h02;
    localparam logic [4:0] FS_SUB     = 5'h03;
    localparam logic [4:0] FS_ADDU    = 5'h04;
    localparam logic [4:0] FS_SUBU    = 5'h05;
    localparam logic [4:0] FS_SLT     = 5'h06;
    localparam logic [4:0] FS_SLTU    = 5'h07;
    localparam logic [4:0] FS_AND     = 5'h08;
    localparam logic [4:0] FS_OR      = 5'h09;
    localparam logic [4:0] FS_XOR     = 5'h0A;
    localparam logic [4:0] FS_NOR     = 5'h0B;
    localparam logic [4:0] FS_SP_INIT = 5'h15;
    localparam logic [4:0] FS_ANDI    = 5'h16;
    localparam logic [4:0] FS_ORI     = 5'h17;
    localparam logic [4:0] FS_LUI     = 5'h18;
    localparam logic [4:0] FS_XORI    = 5'h19;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_HALT  = 6'h0D;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    localparam logic [1:0] PCSEL_BRANCH = 2'b01;
    localparam logic [1:0] PCSEL_JUMP   = 2'b10;

    localparam logic [1:0] DEST_RD  = 2'b00;
    localparam logic [1:0] DEST_RT  = 2'b01;
    localparam logic [1:0] DEST_R29 = 2'b10;

    typedef enum logic [3:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_WB_R,
        S_WB_I,
        S_MEM_ADDR,
        S_LW_RD,
        S_LW_WB,
        S_SW_WR,
        S_BR_CMP,
        S_BR_TAKE,
        S_JUMP,
        S_HALT,
        S_ILLEGAL
    } state_e;

    typedef struct packed {
        logic [4:0] fs;
        logic       pc_ld;
        logic [1:0] pc_sel;
        logic       pc_inc;
        logic       im_cs;
        logic       ir_ld;
        logic       t_sel;
        logic       alu_ld;
        logic       d_en;
        logic [1:0] dest_sel;
        logic       dm_cs;
        logic       dm_rd;
        logic       dm_wr;
        logic       halt;
        logic       illegal;
    } ctrl_out_t;

    // Output image of a state; dec_fs is only consulted for the EXEC states.
    function automatic ctrl_out_t state_outputs(input state_e s, input logic [4:0] dec_fs);
        ctrl_out_t o;
        o = '0;
        case (s)
            S_RESET: begin
                o.fs       = FS_SP_INIT;
                o.alu_ld   = 1'b1;
                o.d_en     = 1'b1;
                o.dest_sel = DEST_R29;
            end
            S_FETCH: begin
                o.im_cs  = 1'b1;
                o.ir_ld  = 1'b1;
                o.pc_inc = 1'b1;
            end
            S_EXEC_R: begin
                o.fs     = dec_fs;
                o.alu_ld = 1'b1;
            end
            S_EXEC_I: begin
                o.fs     = dec_fs;
                o.t_sel  = 1'b1;
                o.alu_ld = 1'b1;
            end
            S_WB_R: begin
                o.d_en     = 1'b1;
                o.dest_sel = DEST_RD;
            end
            S_WB_I, S_LW_WB: begin
                o.d_en     = 1'b1;
                o.dest_sel = DEST_RT;
            end
            S_MEM_ADDR: begin
                o.fs     = FS_ADD;
                o.t_sel  = 1'b1;
                o.alu_ld = 1'b1;
            end
            S_LW_RD: begin
                o.dm_cs = 1'b1;
                o.dm_rd = 1'b1;
            end
            S_SW_WR: begin
                o.dm_cs = 1'b1;
                o.dm_wr = 1'b1;
            end
            S_BR_CMP:  o.fs = FS_SUB;
            S_BR_TAKE: begin
                o.pc_ld  = 1'b1;
                o.pc_sel = PCSEL_BRANCH;
            end
            S_JUMP: begin
                o.pc_ld  = 1'b1;
                o.pc_sel = PCSEL_JUMP;
            end
            S_HALT:    o.halt = 1'b1;
            S_ILLEGAL: begin
                o.halt    = 1'b1;
                o.illegal = 1'b1;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : mips_ctrl_decode
// Purpose  : Combinational opcode/funct decode into the post-DECODE state
//            class and the ALU function code for EXEC_R / EXEC_I.
// Revision : 1.0
// ============================================================================
module mips_ctrl_decode
    import mips_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output state_e     class_o,
    output logic [4:0] fs_o
);

    always_comb begin
        class_o = S_ILLEGAL;
        fs_o    = 5'h00;
        if (opcode_i == OP_RTYPE) begin
            class_o = S_EXEC_R;
            case (funct_i)
                FN_ADD:  fs_o = FS_ADD;
                FN_ADDU: fs_o = FS_ADDU;
                FN_SUB:  fs_o = FS_SUB;
                FN_SUBU: fs_o = FS_SUBU;
                FN_AND:  fs_o = FS_AND;
                FN_OR:   fs_o = FS_OR;
                FN_XOR:  fs_o = FS_XOR;
                FN_NOR:  fs_o = FS_NOR;
                FN_SLT:  fs_o = FS_SLT;
                FN_SLTU: fs_o = FS_SLTU;
                FN_HALT: class_o = S_HALT;
                default: class_o = S_ILLEGAL;
            endcase
        end else begin
            case (opcode_i)
                OP_ADDI: begin class_o = S_EXEC_I;  fs_o = FS_ADD;  end
                OP_SLTI: begin class_o = S_EXEC_I;  fs_o = FS_SLT;  end
                OP_ANDI: begin class_o = S_EXEC_I;  fs_o = FS_ANDI; end
                OP_ORI:  begin class_o = S_EXEC_I;  fs_o = FS_ORI;  end
                OP_XORI: begin class_o = S_EXEC_I;  fs_o = FS_XORI; end
                OP_LUI:  begin class_o = S_EXEC_I;  fs_o = FS_LUI;  end
                OP_LW,
                OP_SW:   class_o = S_MEM_ADDR;
                OP_BEQ,
                OP_BNE:  class_o = S_BR_CMP;
                OP_J:    class_o = S_JUMP;
                default: class_o = S_ILLEGAL;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mips_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mips_ctrl_fsm
// Purpose  : Multi-cycle MIPS control unit; Moore FSM whose outputs are
//            registered images of the state being entered.
// Revision : 1.0
// ============================================================================
module mips_ctrl_fsm
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] ir,
    input  logic        z,
    output logic [4:0]  fs,
    output logic        pc_ld,
    output logic [1:0]  pc_sel,
    output logic        pc_inc,
    output logic        im_cs,
    output logic        ir_ld,
    output logic        t_sel,
    output logic        alu_ld,
    output logic        d_en,
    output logic [1:0]  dest_sel,
    output logic        dm_cs,
    output logic        dm_rd,
    output logic        dm_wr,
    output logic        halt,
    output logic        illegal
);

    state_e     state_q;
    state_e     state_d;
    ctrl_out_t  out_q;
    logic       rst_done_q;

    logic [5:0] w_opcode;
    logic [5:0] w_funct;
    state_e     w_dec_class;
    logic [4:0] w_dec_fs;
    logic       w_br_taken;
    logic       w_unused_ir;

    assign w_opcode    = ir[31:26];
    assign w_funct     = ir[5:0];
    assign w_unused_ir = ^ir[25:6];

    mips_ctrl_decode u_decode (
        .opcode_i (w_opcode),
        .funct_i  (w_funct),
        .class_o  (w_dec_class),
        .fs_o     (w_dec_fs)
    );

    assign w_br_taken = ((w_opcode == OP_BEQ) &&  z) ||
                        ((w_opcode == OP_BNE) && !z);

    always_comb begin
        state_d = state_q;
        case (state_q)
            // Hold RESET for the first edge after release so its outputs show.
            S_RESET:    state_d = rst_done_q ? S_FETCH : S_RESET;
            S_FETCH:    state_d = S_DECODE;
            S_DECODE:   state_d = w_dec_class;
            S_EXEC_R:   state_d = S_WB_R;
            S_EXEC_I:   state_d = S_WB_I;
            S_MEM_ADDR: state_d = (w_opcode == OP_LW) ? S_LW_RD : S_SW_WR;
            S_LW_RD:    state_d = S_LW_WB;
            S_BR_CMP:   state_d = w_br_taken ? S_BR_TAKE : S_FETCH;
            S_WB_R, S_WB_I, S_LW_WB, S_SW_WR,
            S_BR_TAKE, S_JUMP:
                        state_d = S_FETCH;
            S_HALT:     state_d = S_HALT;
            S_ILLEGAL:  state_d = S_ILLEGAL;
            default:    state_d = S_ILLEGAL;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_RESET;
            out_q      <= '0;
            rst_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_q      <= state_outputs(state_d, w_dec_fs);
            rst_done_q <= 1'b1;
        end
    end

    assign fs       = out_q.fs;
    assign pc_ld    = out_q.pc_ld;
    assign pc_sel   = out_q.pc_sel;
    assign pc_inc   = out_q.pc_inc;
    assign im_cs    = out_q.im_cs;
    assign ir_ld    = out_q.ir_ld;
    assign t_sel    = out_q.t_sel;
    assign alu_ld   = out_q.alu_ld;
    assign d_en     = out_q.d_en;
    assign dest_sel = out_q.dest_sel;
    assign dm_cs    = out_q.dm_cs;
    assign dm_rd    = out_q.dm_rd;
    assign dm_wr    = out_q.dm_wr;
    assign halt     = out_q.halt;
    assign illegal  = out_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_mips_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_ctrl_fsm
// Purpose  : Self-checking bench comparing per-cycle outputs against an
//            instruction-level reference model of the control unit.
// Revision : 1.0
// ============================================================================
module tb_mips_ctrl_fsm;

    typedef struct packed {
        logic [4:0] fs;
        logic       pc_ld;
        logic [1:0] pc_sel;
        logic       pc_inc;
        logic       im_cs;
        logic       ir_ld;
        logic       t_sel;
        logic       alu_ld;
        logic       d_en;
        logic [1:0] dest_sel;
        logic       dm_cs;
        logic       dm_rd;
        logic       dm_wr;
        logic       halt;
        logic       illegal;
    } vec_t;

    localparam int R_FUNCT [10] = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2A, 'h2B};
    localparam int R_FS    [10] = '{'h02, 'h04, 'h03, 'h05, 'h08, 'h09, 'h0A, 'h0B, 'h06, 'h07};
    localparam int I_OP    [6]  = '{'h08, 'h0A, 'h0C, 'h0D, 'h0E, 'h0F};
    localparam int I_FS    [6]  = '{'h02, 'h06, 'h16, 'h17, 'h19, 'h18};
    localparam int HALT_HOLD    = 12;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] ir = 32'h0;
    logic        z = 1'b0;
    logic [4:0]  fs;
    logic        pc_ld;
    logic [1:0]  pc_sel;
    logic        pc_inc;
    logic        im_cs;
    logic        ir_ld;
    logic        t_sel;
    logic        alu_ld;
    logic        d_en;
    logic [1:0]  dest_sel;
    logic        dm_cs;
    logic        dm_rd;
    logic        dm_wr;
    logic        halt;
    logic        illegal;

    int   checks = 0;
    int   errors = 0;
    vec_t exp_q[$];
    bit   model_terminal;

    mips_ctrl_fsm dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ir       (ir),
        .z        (z),
        .fs       (fs),
        .pc_ld    (pc_ld),
        .pc_sel   (pc_sel),
        .pc_inc   (pc_inc),
        .im_cs    (im_cs),
        .ir_ld    (ir_ld),
        .t_sel    (t_sel),
        .alu_ld   (alu_ld),
        .d_en     (d_en),
        .dest_sel (dest_sel),
        .dm_cs    (dm_cs),
        .dm_rd    (dm_rd),
        .dm_wr    (dm_wr),
        .halt     (halt),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    function automatic vec_t observed();
        return {fs, pc_ld, pc_sel, pc_inc, im_cs, ir_ld, t_sel, alu_ld,
                d_en, dest_sel, dm_cs, dm_rd, dm_wr, halt, illegal};
    endfunction

    function automatic vec_t v_fetch();
        vec_t e = '0;
        e.im_cs = 1'b1; e.ir_ld = 1'b1; e.pc_inc = 1'b1;
        return e;
    endfunction

    function automatic vec_t v_reset();
        vec_t e = '0;
        e.fs = 5'h15; e.alu_ld = 1'b1; e.d_en = 1'b1; e.dest_sel = 2'b10;
        return e;
    endfunction

    function automatic vec_t v_alu(input int code, input bit imm);
        vec_t e = '0;
        e.fs = 5'(code); e.alu_ld = 1'b1; e.t_sel = imm;
        return e;
    endfunction

    function automatic vec_t v_wb(input logic [1:0] dest);
        vec_t e = '0;
        e.d_en = 1'b1; e.dest_sel = dest;
        return e;
    endfunction

    function automatic vec_t v_pc(input logic [1:0] sel);
        vec_t e = '0;
        e.pc_ld = 1'b1; e.pc_sel = sel;
        return e;
    endfunction

    function automatic vec_t v_mem(input bit wr);
        vec_t e = '0;
        e.dm_cs = 1'b1; e.dm_rd = !wr; e.dm_wr = wr;
        return e;
    endfunction

    function automatic vec_t v_stop(input bit ill);
        vec_t e = '0;
        e.halt = 1'b1; e.illegal = ill;
        return e;
    endfunction

    // Expected outputs for every cycle after FETCH up to and including the next FETCH.
    task automatic model(input logic [31:0] ins, input logic zz);
        int op;
        int fn;
        int hit;
        op = int'(ins[31:26]);
        fn = int'(ins[5:0]);
        hit = -1;
        exp_q.delete();
        model_terminal = 1'b0;
        exp_q.push_back('0);
        if (op == 0) begin
            for (int i = 0; i < 10; i++) if (R_FUNCT[i] == fn) hit = i;
            if (hit >= 0) begin
                exp_q.push_back(v_alu(R_FS[hit], 1'b0));
                exp_q.push_back(v_wb(2'b00));
                exp_q.push_back(v_fetch());
            end else begin
                model_terminal = 1'b1;
                for (int i = 0; i < HALT_HOLD; i++) exp_q.push_back(v_stop(fn != 'h0D));
            end
        end else begin
            for (int i = 0; i < 6; i++) if (I_OP[i] == op) hit = i;
            if (hit >= 0) begin
                exp_q.push_back(v_alu(I_FS[hit], 1'b1));
                exp_q.push_back(v_wb(2'b01));
            end else if (op == 'h23 || op == 'h2B) begin
                exp_q.push_back(v_alu('h02, 1'b1));
                exp_q.push_back(v_mem(op == 'h2B));
                if (op == 'h23) exp_q.push_back(v_wb(2'b01));
            end else if (op == 'h04 || op == 'h05) begin
                exp_q.push_back(v_alu('h03, 1'b0));
                exp_q[$].alu_ld = 1'b0;
                if ((op == 'h04) == (zz == 1'b1)) exp_q.push_back(v_pc(2'b01));
            end else if (op == 'h02) begin
                exp_q.push_back(v_pc(2'b10));
            end else begin
                model_terminal = 1'b1;
                for (int i = 0; i < HALT_HOLD; i++) exp_q.push_back(v_stop(1'b1));
            end
            if (!model_terminal) exp_q.push_back(v_fetch());
        end
    endtask

    // Entered at the negedge inside a FETCH cycle; leaves at the next FETCH negedge.
    task automatic run_instr(input string name, input logic [31:0] ins, input logic zz);
        vec_t act;
        model(ins, zz);
        ir = ins;
        z  = zz;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            act = observed();
            checks++;
            if (act !== exp_q[i]) begin
                errors++;
                $display("FAIL %s ir=%h cycle %0d: got %h expected %h", name, ins, i + 1, act, exp_q[i]);
            end
        end
    endtask

    task automatic do_reset(input string name);
        vec_t act;
        reset_n = 1'b0;
        #1;
        act = observed();
        checks++;
        if (act !== vec_t'('0)) begin
            errors++;
            $display("FAIL %s async_clear: got %h expected %h", name, act, vec_t'('0));
        end
        repeat (2) @(negedge clk);
        act = observed();
        checks++;
        if (act !== vec_t'('0)) begin
            errors++;
            $display("FAIL %s held_clear: got %h expected %h", name, act, vec_t'('0));
        end
        reset_n = 1'b1;
        @(negedge clk);
        act = observed();
        checks++;
        if (act !== v_reset()) begin
            errors++;
            $display("FAIL %s reset_state: got %h expected %h", name, act, v_reset());
        end
        @(negedge clk);
        act = observed();
        checks++;
        if (act !== v_fetch()) begin
            errors++;
            $display("FAIL %s first_fetch: got %h expected %h", name, act, v_fetch());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        #2;
        do_reset("reset_release");
    endtask

    task automatic test_alu();
        run_instr("add", 32'h014B4820, 1'b0);
        run_instr("sub", 32'h014B4822, 1'b1);
        run_instr("sltu", 32'h014B482B, 1'b0);
        run_instr("ori", 32'h3528FFFF, 1'b0);
        run_instr("lui", 32'h3C081234, 1'b1);
    endtask

    task automatic test_mem();
        run_instr("lw", 32'h8D090004, 1'b0);
        run_instr("sw", 32'hAD090008, 1'b1);
    endtask

    task automatic test_branch();
        run_instr("beq_z1", 32'h11090003, 1'b1);
        run_instr("beq_z0", 32'h11090003, 1'b0);
        run_instr("bne_z1", 32'h15090003, 1'b1);
        run_instr("bne_z0", 32'h15090003, 1'b0);
        run_instr("j", 32'h08000010, 1'b0);
    endtask

    task automatic test_halt();
        run_instr("illegal_op", 32'hFC000000, 1'b0);
        do_reset("after_illegal");
        run_instr("halt", 32'h0000000D, 1'b0);
        do_reset("after_halt");
        run_instr("illegal_funct", 32'h0000003F, 1'b0);
        do_reset("after_bad_funct");
    endtask

    task automatic test_reset_mid_lw();
        vec_t act;
        model(32'h8D090004, 1'b0);
        ir = 32'h8D090004;
        z  = 1'b0;
        repeat (3) @(negedge clk);
        act = observed();
        checks++;
        if (act !== exp_q[2]) begin
            errors++;
            $display("FAIL lw_rd_before_reset: got %h expected %h", act, exp_q[2]);
        end
        #2;
        do_reset("reset_mid_lw");
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins;
        for (int n = 0; n < 80; n++) begin
            ins = $urandom;
            case ($urandom_range(0, 11))
                0, 1, 2: begin
                    ins[31:26] = 6'h00;
                    ins[5:0]   = 6'(R_FUNCT[$urandom_range(0, 9)]);
                end
                3, 4: ins[31:26] = 6'(I_OP[$urandom_range(0, 5)]);
                5, 6: ins[31:26] = $urandom_range(0, 1) ? 6'h23 : 6'h2B;
                7, 8: ins[31:26] = $urandom_range(0, 1) ? 6'h04 : 6'h05;
                9:    ins[31:26] = 6'h02;
                10:   ins[31:26] = 6'h00;
                default: ;
            endcase
            run_instr("random", ins, 1'($urandom_range(0, 1)));
            if (model_terminal) do_reset("random_recover");
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mem();
        test_branch();
        test_halt();
        test_reset_mid_lw();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_ctrl_fsm.md
MIPS_CTRL_FSM -- requirements
Module: mips_ctrl_fsm

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; these are the port names `clk` and `reset_n`.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous active-low reset.
- `ir` in 32: instruction register contents.
- `z` in 1: ALU zero flag for the current operands.
- `fs` out 5: ALU function select, driven into ALU FS[4:0].
- `pc_ld` out 1: load PC.
- `pc_sel` out 2: PC source; 00=inc, 01=branch, 10=jump.
- `pc_inc` out 1: PC+4.
- `im_cs` out 1: instruction memory select.
- `ir_ld` out 1: load IR.
- `t_sel` out 1: ALU T source; 0=rt, 1=sign-extended imm16.
- `alu_ld` out 1: load ALU_OUT register.
- `d_en` out 1: register-file write enable.
- `dest_sel` out 2: write address; 00=rd, 01=rt, 10=r29.
- `dm_cs` out 1: data memory select.
- `dm_rd` out 1: data memory read.
- `dm_wr` out 1: data memory write.
- `halt` out 1: sticky halt.
- `illegal` out 1: sticky illegal-opcode flag.

Function
REQ-003 The block SHALL be a Moore FSM with registered outputs; the values listed for a state SHALL be present during every cycle the FSM occupies that state, and outputs not listed SHALL be 0.
REQ-004 The FS codes SHALL be: ADD 02, SUB 03, ADDU 04, SUBU 05, SLT 06, SLTU 07, AND 08, OR 09, XOR 0A, NOR 0B, SP_INIT 15, ANDI 16, ORI 17, LUI 18, XORI 19.
REQ-005 The states and their outputs SHALL be:
- RESET: fs=15, alu_ld=1, d_en=1, dest_sel=10.
- FETCH: im_cs=1, ir_ld=1, pc_inc=1.
- DECODE: no outputs.
- EXEC_R: fs=funct code, alu_ld=1.
- EXEC_I: fs=opcode code, t_sel=1, alu_ld=1.
- WB_R: d_en=1, dest_sel=00.
- WB_I: d_en=1, dest_sel=01.
- MEM_ADDR: fs=02, t_sel=1, alu_ld=1.
- LW_RD: dm_cs=1, dm_rd=1.
- LW_WB: d_en=1, dest_sel=01.
- SW_WR: dm_cs=1, dm_wr=1.
- BR_CMP: fs=03.
- BR_TAKE: pc_ld=1, pc_sel=01.
- JUMP: pc_ld=1, pc_sel=10.
- HALT: halt=1.
- ILLEGAL: illegal=1, halt=1.
REQ-006 The state transitions SHALL be:
- RESET→FETCH→DECODE.
- EXEC_R→WB_R→FETCH.
- EXEC_I→WB_I→FETCH.
- MEM_ADDR→LW_RD→LW_WB→FETCH for lw.
- MEM_ADDR→SW_WR→FETCH for sw.
- JUMP→FETCH and BR_TAKE→FETCH.
- HALT and ILLEGAL are terminal until reset.
REQ-007 DECODE with opcode 00 SHALL select EXEC_R for the following funct values, which map to fs codes as shown:
- 20→02, 21→04, 22→03, 23→05.
- 24→08, 25→09, 26→0A, 27→0B.
- 2A→06, 2B→07.
Funct 0D SHALL select HALT, and any other funct SHALL select ILLEGAL.
REQ-008 DECODE with a nonzero opcode SHALL select the next state as follows:
- EXEC_I for opcode 08 (fs 02), 0A (06), 0C (16), 0D (17), 0E (19), 0F (18).
- MEM_ADDR for opcodes 23 and 2B.
- BR_CMP for opcodes 04 and 05.
- JUMP for opcode 02.
- ILLEGAL for any other opcode.
REQ-009 In BR_CMP, `z` SHALL be sampled at the clock edge that ends the state:
- beq (opcode 04) with z=1 goes to BR_TAKE.
- bne (opcode 05) with z=0 goes to BR_TAKE.
- Otherwise the next state is FETCH.
REQ-010 The per-instruction latency SHALL be:
- R-type/I-type ALU, sw, and taken branch: 4 cycles FETCH-to-FETCH.
- lw: 5 cycles.
- Not-taken branch and j: 3 cycles.
REQ-011 In EXEC_R and EXEC_I, `fs` SHALL be decoded from the `ir` value loaded in FETCH; `ir` SHALL be treated as stable from DECODE until the next FETCH.

Reset
REQ-012 Asserting `reset_n` low SHALL immediately force the state to RESET and all outputs to 0, including `fs`=00, `halt`, and `illegal`, regardless of the current state, including mid-instruction.
REQ-013 On the first rising `clk` edge after `reset_n` deasserts, the block SHALL present the RESET state outputs for exactly one cycle and then enter FETCH.

Structure
REQ-014 A shared package `mips_pkg` SHALL hold the FS code constants, the opcode and funct constants, and the state enumeration.
REQ-015 Opcode/funct-to-fs and next-class decoding SHALL be a combinational sub-module `mips_ctrl_decode`.

Verification
REQ-016 The bench SHALL cover these directed scenarios:
- Reset release: one cycle with fs=15, d_en=1, dest_sel=10; then FETCH with im_cs=ir_ld=pc_inc=1.
- ir=014B4820 (add): EXEC_R with fs=02, alu_ld=1; WB_R with d_en=1, dest_sel=00; FETCH again 4 cycles after the first FETCH.
- ir=8D090004 (lw): MEM_ADDR with fs=02, t_sel=1; LW_RD with dm_cs=dm_rd=1; LW_WB with d_en=1, dest_sel=01; 5-cycle total.
- ir=11090003 (beq):
  - z=1 → BR_TAKE with pc_ld=1, pc_sel=01.
  - z=0 → FETCH directly.
  - Repeat with bne (15090003) and confirm the inverted decision.
- ir=FC000000: illegal=halt=1, held for ≥10 cycles; ir=0000000D: halt=1, illegal=0.
- reset_n pulsed low during LW_RD: all outputs 0 asynchronously, before the next edge; restart as in the reset-release scenario.
